// File: rtl/dsp_sequencer.sv
// Sequences the external multi-cycle DSP unit: latch the command, pulse start,
// wait for done (with timeout), then write back through the shared RF port.
module dsp_sequencer #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start_dsp,
    input  logic [1:0]        i_op_dsp,
    input  logic [4:0]        i_RA,
    input  logic [4:0]        i_RB,
    input  logic [4:0]        i_RW,
    input  logic [DATA_W-1:0] i_ra_data,
    input  logic [DATA_W-1:0] i_rb_data,
    output logic              o_stall,
    output logic              o_dsp_start,
    output logic [1:0]        o_dsp_op,
    output logic [DATA_W-1:0] o_dsp_a,
    output logic [DATA_W-1:0] o_dsp_b,
    input  logic              i_dsp_done,
    input  logic [DATA_W-1:0] i_dsp_result,
    input  logic              i_cpu_wb_en,
    output logic              o_wb_en,
    output logic [4:0]        o_wb_reg,
    output logic [DATA_W-1:0] o_wb_data,
    output logic              o_busy,
    output logic              o_error
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [4:0]          rw_q, rw_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                err_q, err_d;
    logic                hazard;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rw_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rw_q    <= rw_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rw_d    = rw_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (i_start_dsp) begin
                    op_d    = i_op_dsp;
                    rw_d    = i_RW;
                    a_d     = i_ra_data;
                    b_d     = i_rb_data;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                // done takes precedence over a timeout landing on the same cycle
                if (i_dsp_done) begin
                    res_d   = i_dsp_result;
                    state_d = (rw_q != 5'd0) ? S_WB : S_IDLE;
                end else if (cnt_inc == CW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WB: begin
                if (!i_cpu_wb_en) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign hazard = ((i_RA == rw_q) && (i_RA != 5'd0)) ||
                    ((i_RB == rw_q) && (i_RB != 5'd0));

    assign o_busy      = (state_q != S_IDLE);
    assign o_stall     = o_busy && (i_start_dsp || hazard);
    assign o_dsp_start = (state_q == S_ISSUE);
    assign o_dsp_op    = op_q;
    assign o_dsp_a     = a_q;
    assign o_dsp_b     = b_q;
    assign o_wb_en     = (state_q == S_WB) && !i_cpu_wb_en;
    assign o_wb_reg    = rw_q;
    assign o_wb_data   = res_q;
    assign o_error     = err_q;
endmodule

// File: tb/tb_dsp_sequencer.sv
// Directed bench for dsp_sequencer with a transaction-level reference model
// compared against the DUT on every falling clock edge.
module tb_dsp_sequencer;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_start_dsp = 1'b0;
    logic [1:0]    i_op_dsp = '0;
    logic [4:0]    i_RA = '0, i_RB = '0, i_RW = '0;
    logic [DW-1:0] i_ra_data = '0, i_rb_data = '0;
    logic          i_dsp_done = 1'b0;
    logic [DW-1:0] i_dsp_result = '0;
    logic          i_cpu_wb_en = 1'b0;
    logic          o_stall, o_dsp_start, o_wb_en, o_busy, o_error;
    logic [1:0]    o_dsp_op;
    logic [DW-1:0] o_dsp_a, o_dsp_b, o_wb_data;
    logic [4:0]    o_wb_reg;

    int n_chk = 0;
    int n_pass = 0;

    dsp_sequencer #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .i_start_dsp(i_start_dsp), .i_op_dsp(i_op_dsp),
        .i_RA(i_RA), .i_RB(i_RB), .i_RW(i_RW),
        .i_ra_data(i_ra_data), .i_rb_data(i_rb_data),
        .o_stall(o_stall), .o_dsp_start(o_dsp_start), .o_dsp_op(o_dsp_op),
        .o_dsp_a(o_dsp_a), .o_dsp_b(o_dsp_b),
        .i_dsp_done(i_dsp_done), .i_dsp_result(i_dsp_result),
        .i_cpu_wb_en(i_cpu_wb_en),
        .o_wb_en(o_wb_en), .o_wb_reg(o_wb_reg), .o_wb_data(o_wb_data),
        .o_busy(o_busy), .o_error(o_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: one outstanding operation, tracked by what has happened to it
    logic          m_busy, m_issue, m_have_res, m_err;
    int            m_waited;
    logic [1:0]    m_op;
    logic [4:0]    m_rw;
    logic [DW-1:0] m_a, m_b, m_res;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_issue = 0; m_have_res = 0; m_err = 0; m_waited = 0;
            m_op = 0; m_rw = 0; m_a = 0; m_b = 0; m_res = 0;
        end else if (!m_busy) begin
            if (i_start_dsp) begin
                m_busy = 1; m_issue = 1; m_have_res = 0;
                m_op = i_op_dsp; m_rw = i_RW; m_a = i_ra_data; m_b = i_rb_data;
            end
        end else if (m_issue) begin
            m_issue = 0; m_waited = 0;
        end else if (m_have_res) begin
            if (!i_cpu_wb_en) begin m_have_res = 0; m_busy = 0; end
        end else begin
            m_waited++;
            if (i_dsp_done) begin
                m_res = i_dsp_result;
                if (m_rw != 0) m_have_res = 1; else m_busy = 0;
            end else if (m_waited == TO) begin
                m_err = 1; m_busy = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic e_wb, e_stall;
        e_wb    = m_busy && m_have_res && !i_cpu_wb_en;
        e_stall = m_busy && (i_start_dsp || (i_RA == m_rw && i_RA != 0) ||
                             (i_RB == m_rw && i_RB != 0));
        check("busy",  o_busy, m_busy);
        check("start", o_dsp_start, m_busy && m_issue);
        check("stall", o_stall, e_stall);
        check("wb_en", o_wb_en, e_wb);
        check("error", o_error, m_err);
        check("op",    o_dsp_op, m_op);
        check("a",     o_dsp_a, m_a);
        check("b",     o_dsp_b, m_b);
        if (e_wb) begin
            check("wb_reg",  o_wb_reg, m_rw);
            check("wb_data", o_wb_data, m_res);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic accept(input logic [1:0] op, input logic [4:0] rw,
                          input logic [DW-1:0] a, input logic [DW-1:0] b);
        i_start_dsp = 1; i_op_dsp = op; i_RW = rw; i_ra_data = a; i_rb_data = b;
        tick();
        i_start_dsp = 0;
    endtask

    initial begin
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", o_busy, 1'b0);
        check("rst_err", o_error, 1'b0);
        check("rst_a", o_dsp_a, 32'h0);
        reset = 0;
        tick();

        // basic op: done three cycles after the start pulse
        i_RA = 1; i_RB = 2;
        accept(2'd2, 5'd5, 32'h10, 32'h20);
        check("basic_start", o_dsp_start, 1'b1);
        check("basic_a", o_dsp_a, 32'h10);
        check("basic_op", o_dsp_op, 2'd2);
        tick();
        check("basic_nopulse", o_dsp_start, 1'b0);
        tick(); tick();
        i_dsp_done = 1; i_dsp_result = 32'h30;
        tick();
        i_dsp_done = 0;
        check("basic_wb", o_wb_en, 1'b1);
        check("basic_reg", o_wb_reg, 5'd5);
        check("basic_data", o_wb_data, 32'h30);
        tick();
        check("basic_idle", o_busy, 1'b0);
        check("basic_wb_off", o_wb_en, 1'b0);

        // writeback conflict: CPU holds the port for three cycles
        accept(2'd1, 5'd9, 32'h1, 32'h2);
        tick();
        i_dsp_done = 1; i_dsp_result = 32'hABCD; i_cpu_wb_en = 1;
        tick();
        i_dsp_done = 0;
        for (int i = 0; i < 3; i++) begin
            check("conf_hold", o_wb_en, 1'b0);
            if (i < 2) tick();
        end
        i_cpu_wb_en = 0; #1;
        check("conf_wb", o_wb_en, 1'b1);
        check("conf_data", o_wb_data, 32'hABCD);
        tick();
        check("conf_once", o_wb_en, 1'b0);

        // RAW hazard on in-flight destination
        accept(2'd0, 5'd7, 32'h3, 32'h4);
        i_RA = 7; #1;
        check("raw_issue", o_stall, 1'b1);
        tick();
        check("raw_wait", o_stall, 1'b1);
        i_dsp_done = 1; i_dsp_result = 32'h77;
        tick();
        i_dsp_done = 0;
        check("raw_wb", o_stall, 1'b1);
        tick();
        check("raw_idle", o_stall, 1'b0);
        i_RA = 0; i_RB = 0;
        accept(2'd3, 5'd0, 32'h5, 32'h6);
        tick();
        check("rw0_nostall", o_stall, 1'b0);
        i_dsp_done = 1; i_dsp_result = 32'h99;
        tick();
        i_dsp_done = 0;
        check("rw0_idle", o_busy, 1'b0);
        check("rw0_nowb", o_wb_en, 1'b0);

        // back-to-back: second instruction waits, then is accepted in IDLE
        i_RA = 1; i_RB = 2;
        accept(2'd2, 5'd3, 32'h11, 32'h22);
        tick();
        i_start_dsp = 1; i_op_dsp = 2'd1; i_RW = 5'd4; i_ra_data = 32'h55; i_rb_data = 32'h66;
        #1;
        check("b2b_stall", o_stall, 1'b1);
        i_dsp_done = 1; i_dsp_result = 32'h1;
        tick();
        i_dsp_done = 0;
        check("b2b_stall_wb", o_stall, 1'b1);
        tick();
        check("b2b_idle_nostall", o_stall, 1'b0);
        tick();
        i_start_dsp = 0;
        check("b2b_start", o_dsp_start, 1'b1);
        check("b2b_a", o_dsp_a, 32'h55);
        check("b2b_op", o_dsp_op, 2'd1);
        tick();
        i_dsp_done = 1; i_dsp_result = 32'h2;
        tick();
        i_dsp_done = 0;
        tick();

        // done on the final allowed WAIT cycle beats the timeout
        accept(2'd0, 5'd8, 32'h7, 32'h8);
        repeat (8) tick();
        i_dsp_done = 1; i_dsp_result = 32'h88;
        tick();
        i_dsp_done = 0;
        check("edge_noerr", o_error, 1'b0);
        check("edge_wb", o_wb_en, 1'b1);
        tick();

        // timeout: done never arrives
        accept(2'd1, 5'd6, 32'h9, 32'hA);
        repeat (8) tick();
        check("to_not_yet", o_error, 1'b0);
        tick();
        check("to_err", o_error, 1'b1);
        check("to_idle", o_busy, 1'b0);
        i_dsp_done = 1; i_dsp_result = 32'hDEAD;
        tick();
        i_dsp_done = 0;
        check("to_late_done", o_wb_en, 1'b0);
        check("to_sticky", o_error, 1'b1);
        tick();

        // asynchronous reset in the middle of WAIT
        accept(2'd3, 5'd2, 32'hC, 32'hD);
        tick();
        reset = 1; #1;
        check("mid_rst_busy", o_busy, 1'b0);
        check("mid_rst_err", o_error, 1'b0);
        check("mid_rst_a", o_dsp_a, 32'h0);
        check("mid_rst_start", o_dsp_start, 1'b0);
        tick();
        reset = 0;
        i_dsp_done = 1; i_dsp_result = 32'h44;
        tick();
        i_dsp_done = 0;
        check("post_rst_nowb", o_wb_en, 1'b0);
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dsp_sequencer.md
Name: dsp_sequencer

Overview:
- Sequences the external multi-cycle DSP unit driven by the CPU pipeline's `start_dsp`, `op_dsp`, `RA`, `RB` and `RW` decode outputs.
- Latches the DSP command and operands, then issues a one-cycle start pulse and waits for completion.
- Writes the result back into the register file through a shared write port; the normal MEM/WB writeback has priority on that port.
- Raises a stall to the ID stage for structural hazards (DSP busy) and RAW hazards (a read of the in-flight destination).

Parameters:
- DATA_W, 32, operand and result width
- TIMEOUT, 255, maximum cycles in WAIT before abort (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- i_start_dsp  in  1  ID stage decodes a DSP instruction this cycle
- i_op_dsp  in  2  DSP opcode from ID
- i_RA  in  5  rs1 index of the ID instruction (any instruction type)
- i_RB  in  5  rs2 index of the ID instruction
- i_RW  in  5  destination index of the DSP instruction
- i_ra_data  in  DATA_W  register-file read of RA
- i_rb_data  in  DATA_W  register-file read of RB
- o_stall  out  1  freeze IF/ID, insert bubble into ID/EX
- o_dsp_start  out  1  one-cycle start pulse to the DSP unit
- o_dsp_op  out  2  latched opcode
- o_dsp_a  out  DATA_W  latched operand A
- o_dsp_b  out  DATA_W  latched operand B
- i_dsp_done  in  1  DSP result valid (one-cycle pulse)
- i_dsp_result  in  DATA_W  DSP result, valid with i_dsp_done
- i_cpu_wb_en  in  1  memwb_RegWrite (CPU owns the write port this cycle)
- o_wb_en  out  1  DSP writes the register file this cycle
- o_wb_reg  out  5  destination index
- o_wb_data  out  DATA_W  result data
- o_busy  out  1  state ≠ IDLE
- o_error  out  1  sticky timeout flag

Behaviour:
- Reset (async, active-high): state=IDLE, all outputs 0, latched regs 0, timeout counter 0, o_error=0.
- FSM states: IDLE, ISSUE, WAIT, WB.
- IDLE:
  - on i_start_dsp=1, latch op, i_RW, i_ra_data and i_rb_data; go to ISSUE.
  - o_stall=0 in IDLE.
- ISSUE: o_dsp_start=1 for exactly this cycle, counter cleared; go to WAIT. i_dsp_done is ignored in ISSUE.
- WAIT: counter increments each cycle.
  - on i_dsp_done=1, latch i_dsp_result; go to WB if latched RW≠0, else IDLE.
  - if the counter reaches TIMEOUT without done, set o_error=1 and go to IDLE with no writeback.
  - if done arrives in the same cycle the counter hits TIMEOUT, done wins and o_error is not set.
- WB:
  - if i_cpu_wb_en=0: o_wb_en=1, o_wb_reg=latched RW, o_wb_data=latched result; go to IDLE next cycle.
  - if i_cpu_wb_en=1: o_wb_en=0, hold in WB (CPU priority, no starvation limit).
- o_wb_en is high for exactly one cycle per completed op and never while i_cpu_wb_en=1.
- o_stall (states ISSUE, WAIT, WB only) = i_start_dsp OR (i_RA==RWl AND i_RA≠0) OR (i_RB==RWl AND i_RB≠0), where RWl is the latched RW.
- Stall is combinational and drops in the cycle the FSM returns to IDLE. A new DSP instruction stalled in ID is accepted in that IDLE cycle.
- o_dsp_op, o_dsp_a and o_dsp_b hold their latched values from IDLE acceptance until the next acceptance.
- o_error clears only on reset.
- Reset mid-operation aborts immediately: no pending writeback, no start pulse.
- Minimum latency from acceptance to o_wb_en is 4 cycles (IDLE accept, ISSUE, WAIT with done, WB).

Test Plan:
- Basic op: IDLE, start_dsp=1, op=2, RW=5, ra=0x10, rb=0x20; done 3 cycles after start with result=0x30 → start pulse 1 cycle after accept; o_wb_en=1, reg=5, data=0x30 one cycle after done; o_busy=0 after.
- Writeback conflict: done arrives with i_cpu_wb_en=1 held 3 cycles → o_wb_en stays 0 for those 3 cycles, then pulses once with the correct data.
- RAW hazard: in-flight RW=7; ID presents RA=7 → o_stall=1 until return to IDLE. RA=0 with RW=0 → no stall, no writeback.
- Back-to-back DSP instructions: second start_dsp while WAIT → stalled; accepted in the IDLE cycle; second start pulse occurs exactly 1 cycle after that.
- Timeout: TIMEOUT=8, done never asserted → o_error=1 after 8 WAIT cycles, FSM back in IDLE, no o_wb_en; later done pulse is ignored.
- Reset mid-WAIT: assert reset asynchronously → all outputs 0 immediately, state IDLE, no writeback after release.
